// File: rtl/core_regfile_writeback_if.sv
// ============================================================================
// core_regfile_writeback_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles every signal between the register file write side and the rest of
//   the pipeline: the execute-stage writeback bus, the load reservation bus,
//   the load return handshake and the register file's state outputs.
//   The pipeline (and the testbench) take the master side; the register file
//   takes the slave side.
//
// Signals:
//   wb_valid          execute-stage writeback qualifier for this cycle
//   wb_resA/B         destination indices A/B (all ones = no writeback)
//   wb_resA/BValue    data for resA/resB
//   ld_reserve_valid  long-latency load issued, reserve ld_reserve_idx
//   ld_reserve_idx    register reserved by the load
//   ld_ret_valid      load return data valid
//   ld_ret_ready      load return accepted this cycle (from register file)
//   ld_ret_idx        load return destination index
//   ld_ret_value      load return data
//   allRegValue       registered contents of every architectural register
//   pending_mask      bit i set while register i awaits a load return
//   proto_err         sticky protocol-violation flag
// ============================================================================
interface core_regfile_writeback_if #(
    parameter int NREG = 31,
    parameter int IDXW = 5,
    parameter int DW   = 64
);

    logic                       wb_valid;
    logic [IDXW-1:0]            wb_resA;
    logic [IDXW-1:0]            wb_resB;
    logic [DW-1:0]              wb_resAValue;
    logic [DW-1:0]              wb_resBValue;

    logic                       ld_reserve_valid;
    logic [IDXW-1:0]            ld_reserve_idx;

    logic                       ld_ret_valid;
    logic                       ld_ret_ready;
    logic [IDXW-1:0]            ld_ret_idx;
    logic [DW-1:0]              ld_ret_value;

    logic [NREG-1:0][DW-1:0]    allRegValue;
    logic [NREG-1:0]            pending_mask;
    logic                       proto_err;

    // Pipeline side: drives writebacks, reservations and load returns.
    modport master (
        output wb_valid, wb_resA, wb_resB, wb_resAValue, wb_resBValue,
        output ld_reserve_valid, ld_reserve_idx,
        output ld_ret_valid, ld_ret_idx, ld_ret_value,
        input  ld_ret_ready,
        input  allRegValue, pending_mask, proto_err
    );

    // Register file side.
    modport slave (
        input  wb_valid, wb_resA, wb_resB, wb_resAValue, wb_resBValue,
        input  ld_reserve_valid, ld_reserve_idx,
        input  ld_ret_valid, ld_ret_idx, ld_ret_value,
        output ld_ret_ready,
        output allRegValue, pending_mask, proto_err
    );

endinterface

// File: rtl/core_regfile_writeback.sv
// ============================================================================
// core_regfile_writeback
// ----------------------------------------------------------------------------
// Purpose:
//   Write side of the architectural register file (NREG x DW). Registers are
//   written by the execute stage (two results per cycle, A beats B on the same
//   index) and by a deferred long-latency load return path. A pending/killed
//   scoreboard makes sure a late load return never overwrites a younger
//   execute result. All outputs are registered; a write accepted on one clock
//   edge is visible right after that edge, with no internal bypass.
//
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset, sampled on the rising edge of clk
//   bus    core_regfile_writeback_if.slave (writeback, reservation, load
//          return handshake, register contents, pending mask, proto_err)
// ============================================================================
module core_regfile_writeback #(
    parameter int NREG = 31,
    parameter int IDXW = 5,
    parameter int DW   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    core_regfile_writeback_if.slave   bus
);

    // Any index at or above NREG (the all-ones value) means "no register".
    localparam logic [IDXW-1:0] IDX_LIMIT = IDXW'(NREG);

    // Architectural state.
    logic [NREG-1:0][DW-1:0]    r_regs;
    logic [NREG-1:0]            r_pending;
    logic [NREG-1:0]            r_killed;
    logic                       r_protoErr;

    // Decoded request qualifiers.
    logic                       w_resAHit;
    logic                       w_resBHit;
    logic                       w_retIdxOk;
    logic                       w_retReady;
    logic                       w_retXfer;
    logic                       w_reserveHit;

    // Next-state values.
    logic [NREG-1:0][DW-1:0]    w_regsNext;
    logic [NREG-1:0]            w_pendingNext;
    logic [NREG-1:0]            w_killedNext;
    logic                       w_errSet;

    // Execute results only count when the cycle is qualified and the index
    // names a real register; the all-ones index is a "no writeback" marker.
    assign w_resAHit    = bus.wb_valid && (bus.wb_resA < IDX_LIMIT);
    assign w_resBHit    = bus.wb_valid && (bus.wb_resB < IDX_LIMIT);
    assign w_retIdxOk   = (bus.ld_ret_idx < IDX_LIMIT);
    assign w_reserveHit = bus.ld_reserve_valid && (bus.ld_reserve_idx < IDX_LIMIT);

    // The execute writeback always has priority over a load return: the
    // return is stalled whenever it targets a register the execute stage is
    // writing this cycle. Because of this, an execute write and a return
    // transfer can never land on the same register in the same cycle.
    assign w_retReady = !(bus.wb_valid && w_retIdxOk &&
                          ((bus.ld_ret_idx == bus.wb_resA) ||
                           (bus.ld_ret_idx == bus.wb_resB)));
    assign w_retXfer  = bus.ld_ret_valid && w_retReady;

    // Next-state computation, one register at a time. Same-cycle events on a
    // register are applied in age order: the load return first (it belongs
    // to the oldest instruction), then the execute write, then a new
    // reservation (the youngest). Each step sees the result of the previous
    // one, which gives the return-then-reserve and write-then-reserve
    // behaviour without special cases.
    always_comb begin
        w_regsNext    = r_regs;
        w_pendingNext = r_pending;
        w_killedNext  = r_killed;
        // A return to the "no register" index is always a protocol error.
        w_errSet      = w_retXfer && !w_retIdxOk;

        for (int i = 0; i < NREG; i++) begin
            // Load return: only a pending register accepts it. If a younger
            // execute result already replaced the value (killed), the data
            // is dropped but the reservation is still retired.
            if (w_retXfer && (bus.ld_ret_idx == IDXW'(i))) begin
                if (r_pending[i]) begin
                    if (!r_killed[i]) begin
                        w_regsNext[i] = bus.ld_ret_value;
                    end
                    w_pendingNext[i] = 1'b0;
                    w_killedNext[i]  = 1'b0;
                end else begin
                    w_errSet = 1'b1;
                end
            end

            // Execute writes: B first so that A overrides it on a shared
            // index, matching the forwarding stage's priority.
            if (w_resBHit && (bus.wb_resB == IDXW'(i))) begin
                w_regsNext[i] = bus.wb_resBValue;
            end
            if (w_resAHit && (bus.wb_resA == IDXW'(i))) begin
                w_regsNext[i] = bus.wb_resAValue;
            end

            // A younger execute result landing on a register that still
            // awaits a load must survive that load's eventual return.
            if (r_pending[i] &&
                ((w_resAHit && (bus.wb_resA == IDXW'(i))) ||
                 (w_resBHit && (bus.wb_resB == IDXW'(i))))) begin
                w_killedNext[i] = 1'b1;
            end

            // New reservation. Checking the already-updated pending bit means
            // a same-cycle return to this register retires the old
            // reservation first, so only a genuine double reservation is
            // flagged.
            if (w_reserveHit && (bus.ld_reserve_idx == IDXW'(i))) begin
                if (w_pendingNext[i]) begin
                    w_errSet = 1'b1;
                end
                w_pendingNext[i] = 1'b1;
                w_killedNext[i]  = 1'b0;
            end
        end
    end

    // State registers. Reset wins over every other input and also drops any
    // load return in flight, since the scoreboard forgets the reservation.
    // The protocol error flag is sticky until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regs     <= '0;
            r_pending  <= '0;
            r_killed   <= '0;
            r_protoErr <= 1'b0;
        end else begin
            r_regs     <= w_regsNext;
            r_pending  <= w_pendingNext;
            r_killed   <= w_killedNext;
            r_protoErr <= r_protoErr | w_errSet;
        end
    end

    assign bus.ld_ret_ready = w_retReady;
    assign bus.allRegValue  = r_regs;
    assign bus.pending_mask = r_pending;
    assign bus.proto_err    = r_protoErr;

endmodule

// File: tb/tb_core_regfile_writeback.sv
// ============================================================================
// tb_core_regfile_writeback
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for core_regfile_writeback. A table of per-cycle
//   records holds the inputs for one clock and the values expected on
//   ld_ret_ready before the edge and on the registered outputs after it.
//   A hand-written sequence then covers a load return stalled over several
//   execute cycles.
// ============================================================================
module tb_core_regfile_writeback;

    localparam int NREG = 31;
    localparam int IDXW = 5;
    localparam int DW   = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    core_regfile_writeback_if #(.NREG(NREG), .IDXW(IDXW), .DW(DW)) bus ();

    core_regfile_writeback #(.NREG(NREG), .IDXW(IDXW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // One clock of stimulus plus its expected results.
    typedef struct {
        logic            rstN;
        logic            wbValid;
        logic [IDXW-1:0] resA;
        logic [IDXW-1:0] resB;
        logic [DW-1:0]   valA;
        logic [DW-1:0]   valB;
        logic            rsvValid;
        logic [IDXW-1:0] rsvIdx;
        logic            retValid;
        logic [IDXW-1:0] retIdx;
        logic [DW-1:0]   retVal;
        logic            expReady;
        logic [IDXW-1:0] chkIdx;
        logic [DW-1:0]   expVal;
        logic [NREG-1:0] expPend;
        logic            expErr;
        logic            allZero;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [NREG-1:0] bitOf(input int i);
        return NREG'(1) << i;
    endfunction

    function automatic vec_t mk(
        input logic rstN, input logic wbValid,
        input int resA, input int resB,
        input logic [DW-1:0] valA, input logic [DW-1:0] valB,
        input logic rsvValid, input int rsvIdx,
        input logic retValid, input int retIdx, input logic [DW-1:0] retVal,
        input logic expReady, input int chkIdx, input logic [DW-1:0] expVal,
        input logic [NREG-1:0] expPend, input logic expErr, input logic allZero);
        vec_t v;
        v.rstN     = rstN;
        v.wbValid  = wbValid;
        v.resA     = IDXW'(resA);
        v.resB     = IDXW'(resB);
        v.valA     = valA;
        v.valB     = valB;
        v.rsvValid = rsvValid;
        v.rsvIdx   = IDXW'(rsvIdx);
        v.retValid = retValid;
        v.retIdx   = IDXW'(retIdx);
        v.retVal   = retVal;
        v.expReady = expReady;
        v.chkIdx   = IDXW'(chkIdx);
        v.expVal   = expVal;
        v.expPend  = expPend;
        v.expErr   = expErr;
        v.allZero  = allZero;
        return v;
    endfunction

    // Drives one record's inputs at the falling edge, then lets the
    // combinational ready settle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n                = v.rstN;
        bus.wb_valid         = v.wbValid;
        bus.wb_resA          = v.resA;
        bus.wb_resB          = v.resB;
        bus.wb_resAValue     = v.valA;
        bus.wb_resBValue     = v.valB;
        bus.ld_reserve_valid = v.rsvValid;
        bus.ld_reserve_idx   = v.rsvIdx;
        bus.ld_ret_valid     = v.retValid;
        bus.ld_ret_idx       = v.retIdx;
        bus.ld_ret_value     = v.retVal;
        #1;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s row %0d: actual=%0h required=%0h",
                     name, row, actual, expected);
        end
    endtask

    initial begin
        int waited;

        rst_n                = 1'b0;
        bus.wb_valid         = 1'b0;
        bus.wb_resA          = '1;
        bus.wb_resB          = '1;
        bus.wb_resAValue     = '0;
        bus.wb_resBValue     = '0;
        bus.ld_reserve_valid = 1'b0;
        bus.ld_reserve_idx   = '1;
        bus.ld_ret_valid     = 1'b0;
        bus.ld_ret_idx       = '1;
        bus.ld_ret_value     = '0;

        //          rst wb  A   B   valA      valB      rsv idx ret idx retVal     rdy chk expVal     pend                   err allZ
        // Reset with unrelated traffic present: everything must clear.
        vecs.push_back(mk(0, 1,  1,  2, 64'h5,    64'h6,    1,  3, 1,  4, 64'h7,    1,  1, 64'h0,    '0,                    0,  1));
        // Dual writeback, then idle to see both registers.
        vecs.push_back(mk(1, 1,  3,  7, 64'h1111, 64'h2222, 0, 31, 0, 31, 64'h0,    1,  3, 64'h1111, '0,                    0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 0, 31, 64'h0,    1,  7, 64'h2222, '0,                    0,  0));
        // Same index on A and B: A wins. Then A=none, B=4.
        vecs.push_back(mk(1, 1,  5,  5, 64'hA,    64'hB,    0, 31, 0, 31, 64'h0,    1,  5, 64'hA,    '0,                    0,  0));
        vecs.push_back(mk(1, 1, 31,  4, 64'hDD,   64'hC,    0, 31, 0, 31, 64'h0,    1,  4, 64'hC,    '0,                    0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 0, 31, 64'h0,    1,  5, 64'hA,    '0,                    0,  0));
        // wb_valid low: indices and data ignored.
        vecs.push_back(mk(1, 0,  4,  5, 64'hFF,   64'hEE,   0, 31, 0, 31, 64'h0,    1,  4, 64'hC,    '0,                    0,  0));
        // Reserve 9, wait, then return.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1,  9, 0, 31, 64'h0,    1,  9, 64'h0,    bitOf(9),              0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 0, 31, 64'h0,    1,  9, 64'h0,    bitOf(9),              0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 0, 31, 64'h0,    1,  9, 64'h0,    bitOf(9),              0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1,  9, 64'hDEAD, 1,  9, 64'hDEAD, '0,                    0,  0));
        // Reserve 9, execute overwrites it, the stale return is discarded.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1,  9, 0, 31, 64'h0,    1,  9, 64'hDEAD, bitOf(9),              0,  0));
        vecs.push_back(mk(1, 1,  9, 31, 64'h55,   64'h0,    0, 31, 0, 31, 64'h0,    1,  9, 64'h55,   bitOf(9),              0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1,  9, 64'h99,   1,  9, 64'h55,   '0,                    0,  0));
        // Killed bit was cleared: the next load to 9 writes normally.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1,  9, 0, 31, 64'h0,    1,  9, 64'h55,   bitOf(9),              0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1,  9, 64'h77,   1,  9, 64'h77,   '0,                    0,  0));
        // Return to 2 stalled by execute resB=2; the execute write kills the
        // load, so the held return is accepted next cycle and discarded.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1,  2, 0, 31, 64'h0,    1,  2, 64'h0,    bitOf(2),              0,  0));
        vecs.push_back(mk(1, 1, 31,  2, 64'h0,    64'h222,  0, 31, 1,  2, 64'hBEEF, 0,  2, 64'h222,  bitOf(2),              0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1,  2, 64'hBEEF, 1,  2, 64'h222,  '0,                    0,  0));
        // Return to non-pending 6: error, no write, sticky.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1,  6, 64'h66,   1,  6, 64'h0,    '0,                    1,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1, 10, 0, 31, 64'h0,    1,  6, 64'h0,    bitOf(10),             1,  0));
        // Reset mid-wait with a pending register and an error.
        vecs.push_back(mk(0, 0, 31, 31, 64'h0,    64'h0,    0, 31, 0, 31, 64'h0,    1,  9, 64'h0,    '0,                    0,  1));
        // Double reservation without a return: error.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1, 11, 0, 31, 64'h0,    1, 11, 64'h0,    bitOf(11),             0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1, 11, 0, 31, 64'h0,    1, 11, 64'h0,    bitOf(11),             1,  0));
        vecs.push_back(mk(0, 0, 31, 31, 64'h0,    64'h0,    0, 31, 0, 31, 64'h0,    1, 11, 64'h0,    '0,                    0,  1));
        // Return + reserve same index: write, stays pending, no error.
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1, 12, 0, 31, 64'h0,    1, 12, 64'h0,    bitOf(12),             0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    1, 12, 1, 12, 64'h12,   1, 12, 64'h12,   bitOf(12),             0,  0));
        // Execute write + reserve same index: value written, not killed.
        vecs.push_back(mk(1, 1, 13, 31, 64'h34,   64'h0,    1, 13, 0, 31, 64'h0,    1, 13, 64'h34,   bitOf(12) | bitOf(13), 0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1, 13, 64'h56,   1, 13, 64'h56,   bitOf(12),             0,  0));
        vecs.push_back(mk(1, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1, 12, 64'h78,   1, 12, 64'h78,   '0,                    0,  0));
        // Return to index 31 alongside an A=none/B=5 write: ready, error.
        vecs.push_back(mk(1, 1, 31,  5, 64'h0,    64'h5B,   0, 31, 1, 31, 64'h31,   1,  5, 64'h5B,   '0,                    1,  0));
        // Reset with a same-cycle return to 31: reset wins.
        vecs.push_back(mk(0, 0, 31, 31, 64'h0,    64'h0,    0, 31, 1, 31, 64'h0,    1,  5, 64'h0,    '0,                    0,  1));

        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r]);
            checkOutput("ld_ret_ready", r, DW'(bus.ld_ret_ready), DW'(vecs[r].expReady));
            @(posedge clk);
            #1;
            checkOutput("reg", r, bus.allRegValue[vecs[r].chkIdx], vecs[r].expVal);
            checkOutput("pending_mask", r, DW'(bus.pending_mask), DW'(vecs[r].expPend));
            checkOutput("proto_err", r, DW'(bus.proto_err), DW'(vecs[r].expErr));
            if (vecs[r].allZero) begin
                for (int i = 0; i < NREG; i++) begin
                    checkOutput("reg_cleared", r, bus.allRegValue[i], '0);
                end
            end
        end

        // Return to 20 held across three blocking execute writes to 20, then
        // accepted once the execute stage stops targeting it.
        applyStimulus(mk(1, 0, 31, 31, 64'h0, 64'h0, 1, 20, 0, 31, 64'h0,
                         1, 20, 64'h0, bitOf(20), 0, 0));
        @(posedge clk);
        #1;
        checkOutput("seq_reserve20", 100, DW'(bus.pending_mask), DW'(bitOf(20)));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk(1, 1, 20, 31, DW'(256 + k), 64'h0, 0, 31, 1, 20, 64'hABC,
                             0, 20, 64'h0, '0, 0, 0));
            checkOutput("seq_stalled_ready", 101 + k, DW'(bus.ld_ret_ready), DW'(1'b0));
            @(posedge clk);
            #1;
            checkOutput("seq_exec_value", 101 + k, bus.allRegValue[20], DW'(256 + k));
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        bus.wb_resA  = '1;
        #1;
        waited = 0;
        while (!bus.ld_ret_ready && waited < 5) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("seq_ready_within_bound", 104, DW'(waited < 5), DW'(1'b1));
        @(posedge clk);
        #1;
        bus.ld_ret_valid = 1'b0;
        checkOutput("seq_killed_return_dropped", 105, bus.allRegValue[20], DW'(258));
        checkOutput("seq_pending_cleared", 105, DW'(bus.pending_mask), '0);
        checkOutput("seq_no_error", 105, DW'(bus.proto_err), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
